// File: rtl/jt12_pg_sched.sv
// Phase-increment scheduler: per-channel F-number/block registers, a 24-slot walk on clk_en,
// and a shared increment unit. Build with JT12_CH3_SPECIAL_EN for the channel-3 special-frequency registers.

module jt12_pg_inc (
  input  logic [10:0] fnum,
  input  logic [2:0]  block,
  input  logic [8:0]  pm_offset,
  output logic [16:0] phinc_pure
);
  logic [11:0] fnum_mod;

  always_comb begin
    // 12-bit sum deliberately keeps wrap-around from negative PM offsets
    fnum_mod = {fnum, 1'b0} + {{3{pm_offset[8]}}, pm_offset};
    if (block < 3'd2)
      phinc_pure = {5'd0, fnum_mod} >> (3'd2 - block);
    else
      phinc_pure = {5'd0, fnum_mod} << (block - 3'd2);
  end
endmodule

module jt12_pg_sched #(
  parameter int SLOTS_PER_OP = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic        wr,
  input  logic [1:0]  wr_sel,
  input  logic [1:0]  wr_ch,
  input  logic        wr_part,
  input  logic [7:0]  din,
  input  logic        ch3_mode,
  input  logic [8:0]  pm_offset,
  output logic [16:0] phinc,
  output logic        phinc_valid,
  output logic [2:0]  slot_ch,
  output logic [1:0]  slot_op,
  output logic        zero_slot
);
  localparam logic [2:0] CH_LAST = 3'(SLOTS_PER_OP - 1);

  logic [10:0] fnum_r [6];
  logic [2:0]  blk_r  [6];
  logic [2:0]  lat_blk, lat_fhi;
  logic [2:0]  wr_idx;
  logic        wr_ok;

  logic [2:0]  ch_cnt;
  logic [1:0]  op_cnt;
  logic [10:0] fetch_fnum;
  logic [2:0]  fetch_blk;

  logic [10:0] s1_fnum;
  logic [2:0]  s1_blk;
  logic [8:0]  s1_pm;
  logic [2:0]  s1_ch;
  logic [1:0]  s1_op;
  logic        s1_valid;
  logic [16:0] inc_out;

  assign wr_idx = (wr_part ? 3'd3 : 3'd0) + {1'b0, wr_ch};
  assign wr_ok  = wr && (wr_ch != 2'd3);

  // The high-byte latch is shared by all channels and survives the low-byte commit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 6; i++) begin
        fnum_r[i] <= '0;
        blk_r[i]  <= '0;
      end
      lat_blk <= '0;
      lat_fhi <= '0;
    end else if (wr_ok) begin
      case (wr_sel)
        2'd1: begin
          lat_blk <= din[5:3];
          lat_fhi <= din[2:0];
        end
        2'd0: begin
          fnum_r[wr_idx] <= {lat_fhi, din};
          blk_r[wr_idx]  <= lat_blk;
        end
        default: ;
      endcase
    end
  end

`ifdef JT12_CH3_SPECIAL_EN
  logic [10:0] sp_fnum [3];
  logic [2:0]  sp_blk  [3];
  logic [2:0]  sp_lat_blk, sp_lat_fhi;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        sp_fnum[i] <= '0;
        sp_blk[i]  <= '0;
      end
      sp_lat_blk <= '0;
      sp_lat_fhi <= '0;
    end else if (wr_ok) begin
      case (wr_sel)
        2'd3: begin
          sp_lat_blk <= din[5:3];
          sp_lat_fhi <= din[2:0];
        end
        2'd2: begin
          sp_fnum[wr_ch] <= {sp_lat_fhi, din};
          sp_blk[wr_ch]  <= sp_lat_blk;
        end
        default: ;
      endcase
    end
  end
`else
  logic unused_ch3;
  assign unused_ch3 = ch3_mode;
`endif

  always_comb begin
    fetch_fnum = fnum_r[ch_cnt];
    fetch_blk  = blk_r[ch_cnt];
`ifdef JT12_CH3_SPECIAL_EN
    // Channel 2 operators 0..2 take their own frequency; operator 3 keeps the normal one
    if (ch3_mode && ch_cnt == 3'd2 && op_cnt != 2'd3) begin
      fetch_fnum = sp_fnum[op_cnt];
      fetch_blk  = sp_blk[op_cnt];
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_cnt <= '0;
      op_cnt <= '0;
    end else if (clk_en) begin
      if (ch_cnt == CH_LAST) begin
        ch_cnt <= '0;
        op_cnt <= op_cnt + 2'd1;
      end else begin
        ch_cnt <= ch_cnt + 3'd1;
      end
    end
  end

  jt12_pg_inc u_inc (
    .fnum       (s1_fnum),
    .block      (s1_blk),
    .pm_offset  (s1_pm),
    .phinc_pure (inc_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_fnum     <= '0;
      s1_blk      <= '0;
      s1_pm       <= '0;
      s1_ch       <= '0;
      s1_op       <= '0;
      s1_valid    <= 1'b0;
      phinc       <= '0;
      phinc_valid <= 1'b0;
      slot_ch     <= '0;
      slot_op     <= '0;
      zero_slot   <= 1'b0;
    end else if (clk_en) begin
      s1_fnum     <= fetch_fnum;
      s1_blk      <= fetch_blk;
      s1_pm       <= pm_offset;
      s1_ch       <= ch_cnt;
      s1_op       <= op_cnt;
      s1_valid    <= 1'b1;
      phinc       <= inc_out;
      phinc_valid <= s1_valid;
      slot_ch     <= s1_ch;
      slot_op     <= s1_op;
      zero_slot   <= s1_valid && (s1_ch == 3'd0) && (s1_op == 2'd0);
    end
  end
endmodule

// File: tb/tb_jt12_pg_sched.sv
// Self-checking bench for jt12_pg_sched: directed frequency cases plus randomized traffic
// compared against a slot-level reference model kept in the bench.

module tb_jt12_pg_sched;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clk_en = 1'b0;
  logic        wr = 1'b0;
  logic [1:0]  wr_sel = '0;
  logic [1:0]  wr_ch = '0;
  logic        wr_part = 1'b0;
  logic [7:0]  din = '0;
  logic        ch3_mode = 1'b0;
  logic [8:0]  pm_offset = '0;
  logic [16:0] phinc;
  logic        phinc_valid;
  logic [2:0]  slot_ch;
  logic [1:0]  slot_op;
  logic        zero_slot;

  jt12_pg_sched dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .wr(wr), .wr_sel(wr_sel), .wr_ch(wr_ch),
    .wr_part(wr_part), .din(din), .ch3_mode(ch3_mode), .pm_offset(pm_offset),
    .phinc(phinc), .phinc_valid(phinc_valid), .slot_ch(slot_ch), .slot_op(slot_op),
    .zero_slot(zero_slot)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // reference model: register contents, slot index within the frame, one pending result
  int m_fnum [6];
  int m_blk  [6];
  int m_lblk, m_lfhi;
  int s_fnum [3];
  int s_blk  [3];
  int s_lblk, s_lfhi;
  int m_slot, n_en;
  int pend_phinc, pend_ch, pend_op;
  logic [16:0] exp_phinc;
  logic [2:0]  exp_ch;
  logic [1:0]  exp_op;
  logic        exp_valid, exp_zero;

  function automatic int ref_inc(int f, int b, int pm);
    int m;
    m = ((f * 2 + pm) % 4096 + 4096) % 4096;
    if (b < 2) return m / (1 << (2 - b));
    return m * (1 << (b - 2));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 6; i++) begin m_fnum[i] = 0; m_blk[i] = 0; end
    for (int i = 0; i < 3; i++) begin s_fnum[i] = 0; s_blk[i] = 0; end
    m_lblk = 0; m_lfhi = 0; s_lblk = 0; s_lfhi = 0;
    m_slot = 0; n_en = 0; pend_phinc = 0; pend_ch = 0; pend_op = 0;
    exp_phinc = '0; exp_ch = '0; exp_op = '0; exp_valid = 1'b0; exp_zero = 1'b0;
  endtask

  // fetch happens before the write so a same-cycle commit is not visible to that fetch
  task automatic model_edge();
    int ch, op, f, b, p;
    if (clk_en) begin
      n_en++;
      exp_phinc = 17'(pend_phinc);
      exp_ch    = 3'(pend_ch);
      exp_op    = 2'(pend_op);
      exp_valid = (n_en >= 2);
      exp_zero  = exp_valid && pend_ch == 0 && pend_op == 0;
      ch = m_slot % 6;
      op = m_slot / 6;
      f = m_fnum[ch];
      b = m_blk[ch];
`ifdef JT12_CH3_SPECIAL_EN
      if (ch3_mode && ch == 2 && op < 3) begin f = s_fnum[op]; b = s_blk[op]; end
`endif
      p = $signed(pm_offset);
      pend_phinc = ref_inc(f, b, p);
      pend_ch = ch;
      pend_op = op;
      m_slot = (m_slot + 1) % 24;
    end
    if (wr && wr_ch != 2'd3) begin
      case (wr_sel)
        2'd1: begin m_lblk = din[5:3]; m_lfhi = din[2:0]; end
        2'd0: begin
          m_fnum[wr_part * 3 + wr_ch] = m_lfhi * 256 + din;
          m_blk[wr_part * 3 + wr_ch]  = m_lblk;
        end
`ifdef JT12_CH3_SPECIAL_EN
        2'd3: begin s_lblk = din[5:3]; s_lfhi = din[2:0]; end
        2'd2: begin s_fnum[wr_ch] = s_lfhi * 256 + din; s_blk[wr_ch] = s_lblk; end
`endif
        default: ;
      endcase
    end
  endtask

  task automatic cyc(input bit en, input bit w, input logic [1:0] sel, input logic [1:0] ch,
                     input bit part, input logic [7:0] d, input logic [8:0] pm);
    clk_en = en; wr = w; wr_sel = sel; wr_ch = ch; wr_part = part; din = d; pm_offset = pm;
    @(posedge clk);
    model_edge();
    #1;
    wr = 1'b0;
    clk_en = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({phinc_valid, slot_ch, slot_op, zero_slot, phinc} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs got valid=%0b ch=%0d op=%0d zero=%0b phinc=%0d want all 0",
               phinc_valid, slot_ch, slot_op, zero_slot, phinc);
    end
    rst = 1'b0;
  endtask

  task automatic test_frame();
    int zeros = 0;
    for (int k = 1; k <= 26; k++) begin
      cyc(1, 0, 0, 0, 0, 8'h00, 9'd0);
      vectors++;
      if ({phinc_valid, slot_ch, slot_op, zero_slot, phinc} !==
          {exp_valid, exp_ch, exp_op, exp_zero, exp_phinc} || phinc !== 17'd0) begin
        miscompares++;
        $display("FAIL frame_slot k=%0d got v=%0b ch=%0d op=%0d z=%0b ph=%0d want v=%0b ch=%0d op=%0d z=%0b ph=0",
                 k, phinc_valid, slot_ch, slot_op, zero_slot, phinc, exp_valid, exp_ch, exp_op, exp_zero);
      end
      if (k == 1 || k == 2) begin
        vectors++;
        if (phinc_valid !== (k == 2)) begin
          miscompares++;
          $display("FAIL valid_rise k=%0d got %0b want %0b", k, phinc_valid, (k == 2));
        end
      end
      if (k >= 2 && k <= 25 && zero_slot) zeros++;
    end
    vectors++;
    if (zeros != 1) begin
      miscompares++;
      $display("FAIL zero_slot_count got %0d want 1", zeros);
    end
  endtask

  task automatic test_values();
    logic [7:0]  hi [5] = '{8'h22, 8'h22, 8'h07, 8'h3F, 8'h10};
    logic [7:0]  lo [5] = '{8'h69, 8'h69, 8'hFF, 8'hFF, 8'h00};
    logic [8:0]  pm [5] = '{9'd0, 9'h1FE, 9'd0, 9'd1, 9'h1FF};
    int          want [5] = '{4936, 4928, 1023, 131040, 4095};
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 2'd1, 2'd0, 0, hi[i], pm[i]);
      cyc(0, 1, 2'd0, 2'd0, 0, lo[i], pm[i]);
      for (int k = 0; k < 26; k++) begin
        cyc(1, 0, 0, 0, 0, 8'h00, pm[i]);
        vectors++;
        if ({phinc_valid, slot_ch, slot_op, zero_slot, phinc} !==
            {exp_valid, exp_ch, exp_op, exp_zero, exp_phinc}) begin
          miscompares++;
          $display("FAIL values_model case=%0d got ch=%0d op=%0d ph=%0d want ch=%0d op=%0d ph=%0d",
                   i, slot_ch, slot_op, phinc, exp_ch, exp_op, exp_phinc);
        end
        if (k >= 2 && slot_ch == 3'd0) begin
          vectors++;
          if (phinc !== 17'(want[i])) begin
            miscompares++;
            $display("FAIL values_ch0 case=%0d got %0d want %0d", i, phinc, want[i]);
          end
        end
        if (k >= 2 && pm[i] == 9'd0 && slot_ch != 3'd0) begin
          vectors++;
          if (phinc !== 17'd0) begin
            miscompares++;
            $display("FAIL values_other case=%0d ch=%0d got %0d want 0", i, slot_ch, phinc);
          end
        end
      end
    end
  endtask

  task automatic test_latch();
    cyc(0, 1, 2'd1, 2'd0, 0, 8'h3F, 9'h1FF);
    for (int k = 0; k < 26; k++) begin
      cyc(1, 0, 0, 0, 0, 8'h00, 9'h1FF);
      if (k >= 2 && slot_ch == 3'd0) begin
        vectors++;
        if (phinc !== 17'd4095 || phinc !== exp_phinc) begin
          miscompares++;
          $display("FAIL latch_only got %0d want 4095", phinc);
        end
      end
    end
  endtask

  task automatic test_collision();
    int seen = 0;
    cyc(0, 1, 2'd1, 2'd0, 0, 8'h22, 9'd0);
    cyc(0, 1, 2'd0, 2'd0, 0, 8'h69, 9'd0);
    for (int k = 0; k < 6 && (m_slot % 6) != 0; k++) cyc(1, 0, 0, 0, 0, 8'h00, 9'd0);
    cyc(1, 1, 2'd0, 2'd0, 0, 8'h00, 9'd0);
    for (int k = 0; k < 14; k++) begin
      cyc(1, 0, 0, 0, 0, 8'h00, 9'd0);
      vectors++;
      if (phinc !== exp_phinc) begin
        miscompares++;
        $display("FAIL collision_model got %0d want %0d", phinc, exp_phinc);
      end
      if (slot_ch == 3'd0 && seen < 2) begin
        vectors++;
        if (phinc !== (seen == 0 ? 17'd4936 : 17'd4096)) begin
          miscompares++;
          $display("FAIL collision_visit%0d got %0d want %0d", seen, phinc, seen == 0 ? 4936 : 4096);
        end
        seen++;
      end
    end
    vectors++;
    if (seen != 2) begin
      miscompares++;
      $display("FAIL collision_visits got %0d want 2", seen);
    end
  endtask

  task automatic test_ch3();
    int w;
    cyc(0, 1, 2'd3, 2'd0, 0, 8'h11, 9'd0);
    cyc(0, 1, 2'd2, 2'd0, 0, 8'h00, 9'd0);
    cyc(0, 1, 2'd3, 2'd1, 1, 8'h12, 9'd0);
    cyc(0, 1, 2'd2, 2'd1, 1, 8'h00, 9'd0);
    cyc(0, 1, 2'd3, 2'd2, 0, 8'h13, 9'd0);
    cyc(0, 1, 2'd2, 2'd2, 0, 8'h00, 9'd0);
    cyc(0, 1, 2'd1, 2'd2, 0, 8'h11, 9'd0);
    cyc(0, 1, 2'd0, 2'd2, 0, 8'h55, 9'd0);
    for (int mode = 1; mode >= 0; mode--) begin
      ch3_mode = 1'(mode);
      for (int k = 0; k < 28; k++) begin
        cyc(1, 0, 0, 0, 0, 8'h00, 9'd0);
        vectors++;
        if (phinc !== exp_phinc || slot_ch !== exp_ch || slot_op !== exp_op) begin
          miscompares++;
          $display("FAIL ch3_model mode=%0d got ch=%0d op=%0d ph=%0d want ch=%0d op=%0d ph=%0d",
                   mode, slot_ch, slot_op, phinc, exp_ch, exp_op, exp_phinc);
        end
        if (k >= 2 && slot_ch == 3'd2) begin
          w = 682;
`ifdef JT12_CH3_SPECIAL_EN
          if (mode == 1 && slot_op != 2'd3) w = 512 * (slot_op + 1);
`endif
          vectors++;
          if (phinc !== 17'(w)) begin
            miscompares++;
            $display("FAIL ch3_value mode=%0d op=%0d got %0d want %0d", mode, slot_op, phinc, w);
          end
        end
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      if (k % 50 == 0) ch3_mode = 1'($urandom_range(0, 1));
      cyc(($urandom_range(0, 3) != 0), ($urandom_range(0, 9) < 3), 2'($urandom_range(0, 3)),
          2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 8'($urandom), 9'($urandom));
      vectors++;
      if ({phinc_valid, slot_ch, slot_op, zero_slot, phinc} !==
          {exp_valid, exp_ch, exp_op, exp_zero, exp_phinc}) begin
        miscompares++;
        $display("FAIL random k=%0d got v=%0b ch=%0d op=%0d z=%0b ph=%0d want v=%0b ch=%0d op=%0d z=%0b ph=%0d",
                 k, phinc_valid, slot_ch, slot_op, zero_slot, phinc,
                 exp_valid, exp_ch, exp_op, exp_zero, exp_phinc);
      end
    end
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 9; k++) cyc(1, 0, 0, 0, 0, 8'h00, 9'd5);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({phinc_valid, slot_ch, slot_op, zero_slot, phinc} !== '0) begin
      miscompares++;
      $display("FAIL async_reset got valid=%0b ch=%0d op=%0d zero=%0b phinc=%0d want all 0",
               phinc_valid, slot_ch, slot_op, zero_slot, phinc);
    end
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    ch3_mode = 1'b1;
    for (int k = 1; k <= 26; k++) begin
      cyc(1, 0, 0, 0, 0, 8'h00, 9'd0);
      vectors++;
      if ({phinc_valid, slot_ch, slot_op, zero_slot, phinc} !==
          {exp_valid, exp_ch, exp_op, exp_zero, exp_phinc} || phinc !== 17'd0) begin
        miscompares++;
        $display("FAIL post_reset k=%0d got v=%0b ch=%0d op=%0d ph=%0d want v=%0b ch=%0d op=%0d ph=0",
                 k, phinc_valid, slot_ch, slot_op, phinc, exp_valid, exp_ch, exp_op);
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_values();
    test_latch();
    test_collision();
    test_ch3();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
